jk_reg_bank: RTL and testbench
==============================

Name: jk_reg_bank

Overview:
- Parametrised multi-channel JK register bank; the next generation of the single-bit JK flip-flop.
- WIDTH independent JK cells share one clock, reset, enable and a run-time mode that selects the J=K=1 action.
- Adds a parallel synchronous load and registered per-bit change pulses.
- Used as a status/flag register array in control paths; downstream logic consumes q and the chg pulses.

Parameters:
- WIDTH, 8, number of JK channels (1..64).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, 16, width of change-event counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- en  input  1  update enable for JK operation.
- load  input  1  parallel load strobe.
- d  input  WIDTH  parallel load data.
- j  input  WIDTH  per-channel J.
- k  input  WIDTH  per-channel K.
- mode  input  2  J=K=1 action select: 00 toggle, 01 set-priority, 10 reset-priority, 11 hold.
- q  output  WIDTH  register state.
- qn  output  WIDTH  ~q, combinational.
- chg  output  WIDTH  one-cycle pulse per bit that changed on the last edge.
- any_chg  output  1  OR-reduction of chg, registered alongside it.

Behaviour:
- All state updates on rising clk only. No asynchronous paths.
- Priority per edge: reset > load > en > hold.
- Reset (rst==0 at edge):
  - q <= RESET_VAL; chg <= 0; any_chg <= 0.
  - Overrides load/en in the same cycle. Reset mid-operation discards the in-flight update.
- Load (rst==1, load==1): q <= d. Ignores en, j, k and mode.
- JK update (rst==1, load==0, en==1), per bit i:
  - j=0,k=0 -> hold.
  - j=0,k=1 -> 0.
  - j=1,k=0 -> 1.
  - j=1,k=1 -> per mode: 00 ~q[i]; 01 1; 10 0; 11 hold.
- en==0 and load==0: q holds.
- mode is sampled on the same edge as j/k. A mode change takes effect on that edge; there is no pipeline.
- Change pulses:
  - chg <= q_next ^ q on every non-reset edge. A hold edge yields chg=0.
  - any_chg <= |(q_next ^ q).
  - chg is high for exactly one cycle per change. Toggling every cycle keeps chg high continuously.
  - Latency: q updates 1 cycle after the inputs are sampled; chg/any_chg are valid in the same cycle as the new q.
- Load of a value equal to q yields chg=0.
- qn is always the bitwise inverse of q, including during reset.
- Channels are fully independent. No cross-bit interaction except any_chg.

Optional Feature:
- Macro: JK_CHG_CNT_EN.
- Defined:
  - Adds input cnt_clr (1) and output chg_cnt (CNT_W).
  - chg_cnt increments by 1 on each edge where any_chg_next==1.
  - Saturates at all-ones; no wrap.
  - cnt_clr==1 sets it to 0 and has priority over increment.
  - Reset sets it to 0.
- Undefined: ports cnt_clr/chg_cnt are absent; no counter logic is generated.

Test Plan:
- WIDTH=4, RESET_VAL=4'b1010. Hold rst=0 for 2 edges with load=1, d=4'hF -> q=4'b1010, qn=4'b0101, chg=0, any_chg=0.
- Release rst; en=1, mode=00, j=k=4'hF for 3 edges -> q=0101, 1010, 0101; chg=4'hF every cycle; any_chg=1.
- q=4'b0000, en=1, j=4'b0011, k=4'b0110:
  - mode=01 -> q=0011.
  - From 0000, mode=10 -> q=0001.
  - From 0000, mode=11 -> q=0001.
- load=1, en=0, d=4'h9 while q=4'h9 -> q=9, chg=0. Then d=4'h6 -> q=6, chg=4'hF.
- en=1, j=4'hF, k=0, rst=0 on the same edge -> q=RESET_VAL=1010, chg=0. en=0 with toggling j/k -> q unchanged, chg=0.
- With JK_CHG_CNT_EN and CNT_W=3: 10 consecutive toggle edges -> chg_cnt saturates at 7. cnt_clr=1 during a toggle edge -> chg_cnt=0.

Source files
------------

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-channel JK flag register (clk, active-low sync rst, en, load/d, j/k, mode -> q, qn, chg, any_chg; JK_CHG_CNT_EN adds cnt_clr/chg_cnt)
module jk_reg_bank #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [1:0]       mode,
`ifdef JK_CHG_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] chg_cnt,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] chg,
  output logic             any_chg
);
  logic [WIDTH-1:0] jk11, q_jk, q_next, diff;
  always_comb begin
    jk11 = mode == 2'b00 ? ~q : mode == 2'b01 ? {WIDTH{1'b1}} : mode == 2'b10 ? {WIDTH{1'b0}} : q;
    q_jk = (j & ~k) | (~j & ~k & q) | (j & k & jk11);
    q_next = load ? d : en ? q_jk : q;
    diff = q_next ^ q;
  end
  assign qn = ~q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_VAL;
      chg <= '0;
      any_chg <= 1'b0;
    end else begin
      q <= q_next;
      chg <= diff;
      any_chg <= |diff;
    end
  end
`ifdef JK_CHG_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) chg_cnt <= '0;
    else if (|diff && !(&chg_cnt)) chg_cnt <= chg_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: scoreboard bench for jk_reg_bank with WIDTH=4, RESET_VAL=1010
module tb_jk_reg_bank;
  logic clk = 0, rst = 0, en = 0, load = 0;
  logic [3:0] d = 0, j = 0, k = 0;
  logic [1:0] mode = 0;
  logic [3:0] q, qn, chg;
  logic any_chg;
`ifdef JK_CHG_CNT_EN
  logic cnt_clr = 0;
  logic [2:0] chg_cnt;
`endif
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {
    string name;
    logic [3:0] q;
    logic [3:0] chg;
  } exp_t;
  exp_t sb[$];
  jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .j(j), .k(k), .mode(mode),
`ifdef JK_CHG_CNT_EN
    .cnt_clr(cnt_clr), .chg_cnt(chg_cnt),
`endif
    .q(q), .qn(qn), .chg(chg), .any_chg(any_chg)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [3:0] act, logic [3:0] want);
    total_cnt++;
    if (act !== want) $display("FAIL %s: got %b want %b", nm, act, want);
    else pass_cnt++;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".q"}, q, e.q);
      chk({e.name, ".qn"}, qn, ~e.q);
      chk({e.name, ".chg"}, chg, e.chg);
      chk({e.name, ".any"}, {3'b0, any_chg}, {3'b0, |e.chg});
    end
  end
  task automatic step(string nm, logic r, logic ld, logic e_n, logic [1:0] m,
                      logic [3:0] dd, logic [3:0] jj, logic [3:0] kk,
                      logic [3:0] eq, logic [3:0] ec);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; load = ld; en = e_n; mode = m; d = dd; j = jj; k = kk;
    e.name = nm; e.q = eq; e.chg = ec;
    sb.push_back(e);
  endtask
  initial begin
    step("rst0", 0, 1, 0, 2'b00, 4'hF, 4'h0, 4'h0, 4'b1010, 4'h0);
    step("rst1", 0, 1, 0, 2'b00, 4'hF, 4'h0, 4'h0, 4'b1010, 4'h0);
    step("tgl0", 1, 0, 1, 2'b00, 4'h0, 4'hF, 4'hF, 4'b0101, 4'hF);
    step("tgl1", 1, 0, 1, 2'b00, 4'h0, 4'hF, 4'hF, 4'b1010, 4'hF);
    step("tgl2", 1, 0, 1, 2'b00, 4'h0, 4'hF, 4'hF, 4'b0101, 4'hF);
    step("clr0", 1, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'b0000, 4'h5);
    step("setp", 1, 0, 1, 2'b01, 4'h0, 4'b0011, 4'b0110, 4'b0011, 4'h3);
    step("clr1", 1, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'b0000, 4'h3);
    step("rstp", 1, 0, 1, 2'b10, 4'h0, 4'b0011, 4'b0110, 4'b0001, 4'h1);
    step("clr2", 1, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'b0000, 4'h1);
    step("hldp", 1, 0, 1, 2'b11, 4'h0, 4'b0011, 4'b0110, 4'b0001, 4'h1);
    step("ld9a", 1, 1, 0, 2'b00, 4'h9, 4'h0, 4'h0, 4'h9, 4'h8);
    step("ld9b", 1, 1, 0, 2'b00, 4'h9, 4'h0, 4'h0, 4'h9, 4'h0);
    step("ld6", 1, 1, 0, 2'b00, 4'h6, 4'h0, 4'h0, 4'h6, 4'hF);
    step("rstov", 0, 0, 1, 2'b00, 4'h0, 4'hF, 4'h0, 4'b1010, 4'h0);
    step("en0a", 1, 0, 0, 2'b00, 4'h0, 4'hF, 4'hF, 4'b1010, 4'h0);
    step("en0b", 1, 0, 0, 2'b00, 4'h0, 4'h5, 4'hA, 4'b1010, 4'h0);
    step("ldpri", 1, 1, 1, 2'b00, 4'h3, 4'hF, 4'h0, 4'h3, 4'h9);
    step("jk00", 1, 0, 1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0);
    step("jk01", 1, 0, 1, 2'b00, 4'h0, 4'h0, 4'hF, 4'h0, 4'h3);
    step("jk10", 1, 0, 1, 2'b11, 4'h0, 4'h6, 4'h0, 4'h6, 4'h6);
`ifdef JK_CHG_CNT_EN
    step("crst", 0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 4'b1010, 4'h0);
    for (int i = 0; i < 10; i++)
      step("ctgl", 1, 0, 1, 2'b00, 4'h0, 4'hF, 4'hF, (i % 2 == 0) ? 4'b0101 : 4'b1010, 4'hF);
    @(negedge clk);
    chk("cnt_sat", {1'b0, chg_cnt}, 4'd7);
    step("cclr", 1, 0, 1, 2'b00, 4'h0, 4'hF, 4'hF, 4'b1010, 4'hF);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    chk("cnt_clr", {1'b0, chg_cnt}, 4'd0);
`endif
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
